yarvi_fetch: RTL and testbench

Instruction fetch stage directly upstream of decode and the trace disassembler. Owns the PC and issues word requests to instruction memory over a valid/ready request port with variable-latency in-order responses. Buffers returned words in a 2-entry queue and presents valid/pc/insn downstream under a ready handshake. Handles redirects from execute by flushing the queue and discarding in-flight responses.

---
 rtl/yarvi_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_yarvi_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_fetch.sv
// yarvi_fetch: owns the PC, issues word fetches and queues returned words for decode.
// Latency: a response word appears on valid/pc/insn one cycle after it arrives.
// Backpressure: issue is credit-limited by in-flight + queued words; responses are never refused.
// Optional: define YARVI_FETCH_MISALIGN_TRAP_EN to add fetch_misaligned and stall on misaligned redirects.

`ifndef VMSB
`define VMSB 31
`endif

module yarvi_fetch #(
   parameter logic [`VMSB:0] RESET_PC        = '0,
   parameter int             MAX_OUTSTANDING = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             redirect_valid,
   input  logic [`VMSB:0]   redirect_pc,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [`VMSB:0]   imem_req_addr,
   input  logic             imem_resp_valid,
   input  logic [31:0]      imem_resp_data,
   output logic             valid,
   output logic [`VMSB:0]   pc,
   output logic [31:0]      insn,
   input  logic             ready
`ifdef YARVI_FETCH_MISALIGN_TRAP_EN
   ,
   output logic             fetch_misaligned
`endif
);

   localparam int AW = `VMSB + 1;
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
   localparam logic [CW:0]   MAX_CNT  = (CW+1)'(MAX_OUTSTANDING);

   // Circular pointer advance; depth need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Control state.
   logic            started_q;
   logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   outst_q, outst_d;     // live requests, excluding ones marked for drop
   logic [CW-1:0]   drop_q, drop_d;       // stale responses still to be discarded
   logic [CW-1:0]   occ_q, occ_d;         // output queue occupancy
   logic [PW-1:0]   if_rd_q, if_rd_d, if_wr_q, if_wr_d;
   logic [PW-1:0]   oq_rd_q, oq_rd_d, oq_wr_q, oq_wr_d;

   // Storage: request PCs in flight, and the output queue of {pc, insn}.
   logic [AW-1:0]   if_pc_q   [MAX_OUTSTANDING];
   logic [AW-1:0]   oq_pc_q   [MAX_OUTSTANDING];
   logic [31:0]     oq_insn_q [MAX_OUTSTANDING];

   logic            credit_ok;
   logic            req_fire;
   logic            resp_take;
   logic            pop;
   logic            misalign_hold;
   logic [CW:0]     drop_sum;

`ifdef YARVI_FETCH_MISALIGN_TRAP_EN
   logic            misalign_q, misalign_d;
   logic            redir_misaligned;

   assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
   assign misalign_hold    = misalign_q;
   assign fetch_misaligned = misalign_q;

   // Misaligned-redirect flag: held until an aligned redirect arrives.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   // Flag next state: every redirect re-evaluates it.
   always_comb begin
      misalign_d = misalign_q;
      if (redirect_valid) begin
         misalign_d = redir_misaligned;
      end
   end
`else
   assign misalign_hold = 1'b0;
`endif

   // Downstream view is the head of the output queue.
   assign valid = (occ_q != '0);
   assign pc    = oq_pc_q[oq_rd_q];
   assign insn  = oq_insn_q[oq_rd_q];

   // Issue gating and handshake qualifiers; credits cover in-flight and queued words.
   always_comb begin
      credit_ok      = (({1'b0, outst_q} + {1'b0, occ_q}) < MAX_CNT);
      imem_req_valid = started_q && !redirect_valid && !misalign_hold && credit_ok;
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      resp_take      = imem_resp_valid && (drop_q == '0) && (outst_q != '0) && !redirect_valid;
      pop            = valid && ready;
   end

   // Next-state for PC, counters and queue pointers; redirect overrides everything.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      occ_d      = occ_q;
      if_rd_d    = if_rd_q;
      if_wr_d    = if_wr_q;
      oq_rd_d    = oq_rd_q;
      oq_wr_d    = oq_wr_q;
      drop_sum   = '0;

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~AW'(3);
`ifdef YARVI_FETCH_MISALIGN_TRAP_EN
         if (redir_misaligned) begin
            fetch_pc_d = redirect_pc;
         end
`endif
         // Everything still in flight becomes stale; a response landing now is
         // one of them and is consumed immediately.
         drop_sum = {1'b0, drop_q} + {1'b0, outst_q};
         if (imem_resp_valid && (drop_sum != '0)) begin
            drop_sum = drop_sum - (CW+1)'(1);
         end
         drop_d  = (drop_sum > MAX_CNT) ? MAX_CNT[CW-1:0] : drop_sum[CW-1:0];
         outst_d = '0;
         occ_d   = '0;
         if_rd_d = '0;
         if_wr_d = '0;
         oq_rd_d = '0;
         oq_wr_d = '0;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + AW'(4);
            if_wr_d    = ptr_inc(if_wr_q);
         end
         if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (resp_take) begin
            if_rd_d = ptr_inc(if_rd_q);
            oq_wr_d = ptr_inc(oq_wr_q);
         end
         if (pop) begin
            oq_rd_d = ptr_inc(oq_rd_q);
         end
         outst_d = outst_q + CW'(req_fire) - CW'(resp_take);
         occ_d   = occ_q + CW'(resp_take) - CW'(pop);
      end
   end

   // Control registers; fetching is enabled on the first edge after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         started_q  <= 1'b0;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         occ_q      <= '0;
         if_rd_q    <= '0;
         if_wr_q    <= '0;
         oq_rd_q    <= '0;
         oq_wr_q    <= '0;
      end else begin
         started_q  <= 1'b1;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         occ_q      <= occ_d;
         if_rd_q    <= if_rd_d;
         if_wr_q    <= if_wr_d;
         oq_rd_q    <= oq_rd_d;
         oq_wr_q    <= oq_wr_d;
      end
   end

   // In-flight PC queue: remember the address of every accepted request.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if_pc_q[i] <= '0;
         end
      end else if (req_fire) begin
         if_pc_q[if_wr_q] <= fetch_pc_q;
      end
   end

   // Output queue: pair each live response with its request PC.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            oq_pc_q[i]   <= '0;
            oq_insn_q[i] <= '0;
         end
      end else if (resp_take) begin
         oq_pc_q[oq_wr_q]   <= if_pc_q[if_rd_q];
         oq_insn_q[oq_wr_q] <= imem_resp_data;
      end
   end

endmodule

// File: tb/tb_yarvi_fetch.sv
// Directed bench for yarvi_fetch with a fixed-latency, always-ready memory model.
// Memory words carry an epoch tag so stale responses are distinguishable.
`timescale 1ns/1ps

`ifndef VMSB
`define VMSB 31
`endif

module tb_yarvi_fetch;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             redirect_valid;
   logic [`VMSB:0]   redirect_pc;
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [`VMSB:0]   imem_req_addr;
   logic             imem_resp_valid;
   logic [31:0]      imem_resp_data;
   logic             valid;
   logic [`VMSB:0]   pc;
   logic [31:0]      insn;
   logic             ready;
`ifdef YARVI_FETCH_MISALIGN_TRAP_EN
   logic             fetch_misaligned;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   yarvi_fetch #(.RESET_PC(32'h0000_0100), .MAX_OUTSTANDING(2)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .valid           (valid),
      .pc              (pc),
      .insn            (insn),
      .ready           (ready)
`ifdef YARVI_FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misaligned(fetch_misaligned)
`endif
   );

   // Memory model: fixed latency pipeline, contents = {epoch, addr[23:0]}.
   logic [2:0]       lat_m1 = 3'd0;
   logic [7:0]       epoch  = 8'd0;
   logic [7:0]       mem_v  = '0;
   logic [31:0]      mem_a [8];
   logic [7:0]       mem_e [8];
   int               req_cnt = 0;
   logic [31:0]      req_log [16];

   always @(posedge clock) begin
      mem_v    <= {mem_v[6:0], imem_req_valid && imem_req_ready};
      mem_a[0] <= imem_req_addr;
      mem_e[0] <= epoch;
      for (int i = 1; i < 8; i++) begin
         mem_a[i] <= mem_a[i-1];
         mem_e[i] <= mem_e[i-1];
      end
      if (imem_req_valid && imem_req_ready) begin
         req_cnt                <= req_cnt + 1;
         req_log[req_cnt % 16]  <= imem_req_addr;
      end
   end

   assign imem_resp_valid = mem_v[lat_m1];
   assign imem_resp_data  = {mem_e[lat_m1], mem_a[lat_m1][23:0]};

   function automatic logic [31:0] exp_insn(input logic [31:0] a);
      return {epoch, a[23:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Wait (bounded) for the next head beat, check it, and let ready=1 consume it.
   task automatic wait_beat(input logic [31:0] exp_pc, input string tag);
      int n = 0;
      while (!valid && n < 30) begin
         step();
         n++;
      end
      chk({tag, " valid"}, {31'b0, valid}, 32'd1);
      chk({tag, " pc"}, pc, exp_pc);
      chk({tag, " insn"}, insn, exp_insn(exp_pc));
      step();
   endtask

   // Long reset so any response still in the memory pipe lands while in reset.
   task automatic do_reset();
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      epoch          = epoch + 8'd1;
      step(8);
      reset_n = 1'b1;
   endtask

   task automatic wait_two_reqs(input int base, input string tag);
      int n = 0;
      while ((req_cnt - base) < 2 && n < 20) begin
         step();
         n++;
      end
      chk({tag, " reqs"}, req_cnt - base, 32'd2);
   endtask

   initial begin
      int  base;
      int  n;
      bit  found;

      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      ready          = 1'b1;
      step(3);

      // Reset state.
      chk("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst req_addr", imem_req_addr, 32'h100);
      chk("rst valid", {31'b0, valid}, 32'd0);
      chk("rst pc", pc, 32'h0);
      chk("rst insn", insn, 32'h0);
`ifdef YARVI_FETCH_MISALIGN_TRAP_EN
      chk("rst misaligned", {31'b0, fetch_misaligned}, 32'd0);
`endif

      // Streaming with 1-cycle memory.
      reset_n = 1'b1;
      wait_beat(32'h100, "s1 b0");
      wait_beat(32'h104, "s1 b1");
      wait_beat(32'h108, "s1 b2");

      // Downstream stalled: exactly two requests, queue full, issue stops.
      ready = 1'b0;
      do_reset();
      base = req_cnt;
      step(10);
      chk("s2 req count", req_cnt - base, 32'd2);
      chk("s2 req0 addr", req_log[base % 16], 32'h100);
      chk("s2 req1 addr", req_log[(base + 1) % 16], 32'h104);
      chk("s2 req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("s2 valid", {31'b0, valid}, 32'd1);
      chk("s2 head pc", pc, 32'h100);
      ready = 1'b1;
      wait_beat(32'h100, "s2 b0");
      wait_beat(32'h104, "s2 b1");
      wait_beat(32'h108, "s2 b2");
      wait_beat(32'h10C, "s2 b3");

      // 3-cycle memory, redirect with two requests outstanding.
      lat_m1 = 3'd2;
      do_reset();
      base = req_cnt;
      wait_two_reqs(base, "s3");
      chk("s3 no beat yet", {31'b0, valid}, 32'd0);
      epoch          = epoch + 8'd1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      #1;
      chk("s3 req gated", {31'b0, imem_req_valid}, 32'd0);
      step();
      redirect_valid = 1'b0;
      chk("s3 valid after redir", {31'b0, valid}, 32'd0);
      wait_beat(32'h200, "s3 b0");
      wait_beat(32'h204, "s3 b1");

      // Redirect coincident with a live response and a pop.
      lat_m1 = 3'd0;
      do_reset();
      found = 1'b0;
      n     = 0;
      while (!found && n < 20) begin
         step();
         n++;
         if (valid && imem_resp_valid && ready) found = 1'b1;
      end
      chk("s4 coincidence", {31'b0, found}, 32'd1);
      epoch          = epoch + 8'd1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h400;
      #1;
      chk("s4 req gated", {31'b0, imem_req_valid}, 32'd0);
      step();
      redirect_valid = 1'b0;
      chk("s4 valid after redir", {31'b0, valid}, 32'd0);
      wait_beat(32'h400, "s4 b0");
      wait_beat(32'h404, "s4 b1");
      wait_beat(32'h408, "s4 b2");

      // Reset mid-stream with two requests outstanding.
      lat_m1 = 3'd2;
      do_reset();
      base = req_cnt;
      wait_two_reqs(base, "s5");
      reset_n = 1'b0;
      #1;
      chk("s5 rst req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("s5 rst req_addr", imem_req_addr, 32'h100);
      chk("s5 rst valid", {31'b0, valid}, 32'd0);
      chk("s5 rst pc", pc, 32'h0);
      chk("s5 rst insn", insn, 32'h0);
      epoch = epoch + 8'd1;
      step(6);
      reset_n = 1'b1;
      wait_beat(32'h100, "s5 b0");
      wait_beat(32'h104, "s5 b1");

      // Misaligned redirect target.
      epoch          = epoch + 8'd1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h202;
      step();
      redirect_valid = 1'b0;
      #1;
`ifdef YARVI_FETCH_MISALIGN_TRAP_EN
      chk("s6 misaligned set", {31'b0, fetch_misaligned}, 32'd1);
      chk("s6 req held", {31'b0, imem_req_valid}, 32'd0);
      base = req_cnt;
      step(6);
      chk("s6 no requests", req_cnt - base, 32'd0);
      chk("s6 no beats", {31'b0, valid}, 32'd0);
      epoch          = epoch + 8'd1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      step();
      redirect_valid = 1'b0;
      #1;
      chk("s6 misaligned clr", {31'b0, fetch_misaligned}, 32'd0);
      wait_beat(32'h300, "s6 b0");
      wait_beat(32'h304, "s6 b1");
`else
      chk("s6 req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("s6 masked addr", imem_req_addr, 32'h200);
      wait_beat(32'h200, "s6 b0");
      wait_beat(32'h204, "s6 b1");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
